// File: rtl/game_status_if.sv
// Game-status interface: bundles the game-control pulses, the line-clear
// valid/ready handshake and the status outputs shown by the on-screen UI.
//   master : playfield/controller side (drives New_Game, Top_Out, Clear_*)
//   slave  : game_status_tracker side (drives Clear_Ready and all status)
interface game_status_if;
  logic       New_Game;
  logic       Top_Out;
  logic       Clear_Valid;
  logic [2:0] Clear_Lines;
  logic       Clear_Ready;
  logic [6:0] Score;
  logic [3:0] Score_Tens;
  logic [3:0] Score_Ones;
  logic [6:0] Highest;
  logic       Win;
  logic       Lose;

  modport master (
    output New_Game, Top_Out, Clear_Valid, Clear_Lines,
    input  Clear_Ready, Score, Score_Tens, Score_Ones, Highest, Win, Lose
  );

  modport slave (
    input  New_Game, Top_Out, Clear_Valid, Clear_Lines,
    output Clear_Ready, Score, Score_Tens, Score_Ones, Highest, Win, Lose
  );
endinterface

// File: rtl/game_status_tracker.sv
// game_status_tracker: converts line-clear events into points, accumulates
// them one point per cycle into a binary score with parallel BCD digits,
// tracks the best score since reset and runs the IDLE/PLAY/WIN/LOSE FSM.
// Ports:
//   Clk     : system clock, rising edge
//   Reset_n : asynchronous active-low reset
//   gs      : game_status_if.slave (control pulses, clear handshake, status)
module game_status_tracker #(
  parameter logic [6:0] WIN_SCORE = 7'd50,
  parameter logic [6:0] SCORE_MAX = 7'd99,
  parameter logic [3:0] PTS_1     = 4'd1,
  parameter logic [3:0] PTS_2     = 4'd3,
  parameter logic [3:0] PTS_3     = 4'd5,
  parameter logic [3:0] PTS_4     = 4'd8
) (
  input  logic          Clk,
  input  logic          Reset_n,
  game_status_if.slave  gs
);

  typedef enum logic [1:0] {IDLE, PLAY, WIN, LOSE} state_t;

  state_t     state, state_n;
  logic [6:0] score, score_n;
  logic [3:0] tens, tens_n;
  logic [3:0] ones, ones_n;
  logic [3:0] pending, pending_n;
  logic [6:0] highest;
  logic       ready;
  logic       xfer;

  // Illegal line counts are accepted but award nothing.
  function automatic logic [3:0] pts(input logic [2:0] lines);
    case (lines)
      3'd1:    pts = PTS_1;
      3'd2:    pts = PTS_2;
      3'd3:    pts = PTS_3;
      3'd4:    pts = PTS_4;
      default: pts = 4'd0;
    endcase
  endfunction

  assign ready = (state == PLAY) && (pending == 4'd0);
  assign xfer  = gs.Clear_Valid && ready;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      score   <= '0;
      tens    <= '0;
      ones    <= '0;
      pending <= '0;
      highest <= '0;
    end else begin
      state   <= state_n;
      score   <= score_n;
      tens    <= tens_n;
      ones    <= ones_n;
      pending <= pending_n;
      // Follows the registered score, so it lags Score by one cycle.
      if (score > highest) highest <= score;
    end
  end

  always_comb begin
    state_n   = state;
    score_n   = score;
    tens_n    = tens;
    ones_n    = ones;
    pending_n = pending;
    if (gs.New_Game) begin
      state_n   = PLAY;
      score_n   = '0;
      tens_n    = '0;
      ones_n    = '0;
      pending_n = '0;
    end else if (state == PLAY) begin
      if (gs.Top_Out) begin
        // Loss beats everything else in PLAY; undelivered points are lost.
        state_n   = LOSE;
        pending_n = '0;
      end else if (pending != 4'd0) begin
        if (score == SCORE_MAX) begin
          pending_n = '0;
        end else begin
          score_n   = score + 7'd1;
          pending_n = pending - 4'd1;
          if (ones == 4'd9) begin
            ones_n = 4'd0;
            tens_n = tens + 4'd1;
          end else begin
            ones_n = ones + 4'd1;
          end
        end
      end else if (score >= WIN_SCORE) begin
        // Win is only evaluated once accumulation has drained; a clear
        // offered in this same cycle is consumed and discarded.
        state_n = WIN;
      end else if (xfer) begin
        pending_n = pts(gs.Clear_Lines);
      end
    end
  end

  assign gs.Clear_Ready = ready;
  assign gs.Score       = score;
  assign gs.Score_Tens  = tens;
  assign gs.Score_Ones  = ones;
  assign gs.Highest     = highest;
  assign gs.Win         = (state == WIN);
  assign gs.Lose        = (state == LOSE);

endmodule

// File: tb/tb_game_status_tracker.sv
module tb_game_status_tracker;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 Clk = ~Clk;

  game_status_if g  ();
  game_status_if g9 ();

  game_status_tracker dut (.Clk(Clk), .Reset_n(Reset_n), .gs(g));
  game_status_tracker #(.WIN_SCORE(7'd99)) dut99 (.Clk(Clk), .Reset_n(Reset_n), .gs(g9));

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // All driving and sampling happens at the falling edge.
  task automatic tick();
    @(negedge Clk);
  endtask

  // One line-clear on the selected tracker, then wait for the drain.
  task automatic do_clear(input bit sel, input logic [2:0] n);
    int k;
    if (sel) begin g9.Clear_Valid = 1'b1; g9.Clear_Lines = n; end
    else     begin g.Clear_Valid  = 1'b1; g.Clear_Lines  = n; end
    tick();
    g.Clear_Valid = 1'b0; g9.Clear_Valid = 1'b0;
    k = 0;
    while (!(sel ? g9.Clear_Ready : g.Clear_Ready) && k < 20) begin
      tick(); k++;
    end
    if (k >= 20) chk("drain_timeout", k, 0);
  endtask

  task automatic new_game(input bit sel);
    if (sel) g9.New_Game = 1'b1; else g.New_Game = 1'b1;
    tick();
    g.New_Game = 1'b0; g9.New_Game = 1'b0;
  endtask

  initial begin
    int exp_ones [5] = '{9, 0, 1, 2, 3};
    int exp_tens [5] = '{0, 1, 1, 1, 1};
    g.New_Game = 0;  g.Top_Out = 0;  g.Clear_Valid = 0;  g.Clear_Lines = 0;
    g9.New_Game = 0; g9.Top_Out = 0; g9.Clear_Valid = 0; g9.Clear_Lines = 0;
    tick(); tick();
    chk("rst_score", g.Score, 0);
    chk("rst_ready", g.Clear_Ready, 0);
    chk("rst_win_lose", {g.Win, g.Lose}, 0);
    chk("rst_highest", g.Highest, 0);
    Reset_n = 1'b1;
    tick();
    chk("idle_ready", g.Clear_Ready, 0);

    // 1: 2-line clear -> 3 points, ready low for 3 cycles
    new_game(0);
    chk("t1_ready_play", g.Clear_Ready, 1);
    g.Clear_Valid = 1; g.Clear_Lines = 3'd2;
    tick();
    g.Clear_Valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("t1_ready_busy", g.Clear_Ready, 0);
      tick();
    end
    chk("t1_ready_back", g.Clear_Ready, 1);
    chk("t1_score", g.Score, 3);
    chk("t1_digits", {g.Score_Tens, g.Score_Ones}, 8'h03);
    chk("t1_highest_lag", g.Highest, 2);
    tick();
    chk("t1_highest", g.Highest, 3);

    // 2: BCD wrap from 8 by 5 points
    new_game(0);
    chk("t2_newgame_score", g.Score, 0);
    chk("t2_highest_kept", g.Highest, 3);
    do_clear(0, 3'd4);
    chk("t2_score8", g.Score, 8);
    g.Clear_Valid = 1; g.Clear_Lines = 3'd3;
    tick();
    g.Clear_Valid = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_ones", g.Score_Ones, exp_ones[i]);
      chk("t2_tens", g.Score_Tens, exp_tens[i]);
    end
    chk("t2_score13", g.Score, 13);

    // 3: 47 + 8 -> 55, win only after the drain
    for (int i = 0; i < 4; i++) do_clear(0, 3'd4);
    do_clear(0, 3'd1);
    do_clear(0, 3'd1);
    chk("t3_score47", g.Score, 47);
    g.Clear_Valid = 1; g.Clear_Lines = 3'd4;
    tick();
    g.Clear_Valid = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t3_no_early_win", g.Win, 0);
    end
    chk("t3_score55", g.Score, 55);
    tick();
    chk("t3_win", g.Win, 1);
    chk("t3_ready_win", g.Clear_Ready, 0);
    g.Clear_Valid = 1; g.Clear_Lines = 3'd4;
    tick(); tick();
    g.Clear_Valid = 0;
    chk("t3_score_held", g.Score, 55);
    chk("t3_digits", {g.Score_Tens, g.Score_Ones}, 8'h55);

    // 6a: illegal line count consumed, no points
    new_game(0);
    chk("t6_highest_kept", g.Highest, 55);
    do_clear(0, 3'd4);
    do_clear(0, 3'd1);
    do_clear(0, 3'd1);
    g.Clear_Valid = 1; g.Clear_Lines = 3'd0;
    tick();
    g.Clear_Valid = 0;
    chk("t6_ready_zero", g.Clear_Ready, 1);
    tick();
    chk("t6_score10", g.Score, 10);

    // 4: Top_Out during accumulation freezes score at 12
    g.Clear_Valid = 1; g.Clear_Lines = 3'd4;
    tick();
    g.Clear_Valid = 0;
    tick(); tick();
    chk("t4_score12", g.Score, 12);
    g.Top_Out = 1;
    tick();
    g.Top_Out = 0;
    chk("t4_lose", g.Lose, 1);
    chk("t4_win", g.Win, 0);
    tick(); tick();
    chk("t4_frozen", g.Score, 12);
    chk("t4_ready", g.Clear_Ready, 0);

    // 6b: New_Game from LOSE
    new_game(0);
    chk("t6_score0", g.Score, 0);
    chk("t6_lose_clear", g.Lose, 0);
    chk("t6_highest", g.Highest, 55);

    // 5: saturation at 99 with WIN_SCORE = 99
    new_game(1);
    for (int i = 0; i < 12; i++) do_clear(1, 3'd4);
    do_clear(1, 3'd1);
    chk("t5_score97", g9.Score, 97);
    g9.Clear_Valid = 1; g9.Clear_Lines = 3'd4;
    tick();
    g9.Clear_Valid = 0;
    tick(); tick();
    chk("t5_score99", g9.Score, 99);
    chk("t5_digits", {g9.Score_Tens, g9.Score_Ones}, 8'h99);
    tick();
    chk("t5_sat", g9.Score, 99);
    chk("t5_pending_drop", g9.Clear_Ready, 1);
    tick();
    chk("t5_win", g9.Win, 1);
    chk("t5_final", g9.Score, 99);

    // Async reset mid-accumulation
    new_game(0);
    g.Clear_Valid = 1; g.Clear_Lines = 3'd4;
    tick();
    g.Clear_Valid = 0;
    tick();
    chk("rst_mid_pre", g.Score, 1);
    #2 Reset_n = 1'b0;
    #1;
    chk("rst_mid_score", g.Score, 0);
    chk("rst_mid_highest", g.Highest, 0);
    chk("rst_mid_ready", g.Clear_Ready, 0);
    tick(); tick();
    chk("rst_mid_hold", g.Score, 0);
    Reset_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
